// File: rtl/data_mem_arbiter.sv
// Shared data memory behind a round-robin arbiter for the cores' M-stage ports.
// Each grant uses one ARB edge for the RAM access, then one RESP edge that raises the ready pulse.
module data_mem_arbiter #(
  parameter int  NUM_CORES     = 4,
  parameter int  REG_WIDTH     = 8,
  parameter int  CORE_ID_WIDTH = 2,
  localparam int ADDR_WIDTH    = CORE_ID_WIDTH + REG_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [2*NUM_CORES-1:0]          enable_M_bus,
  input  logic [ADDR_WIDTH*NUM_CORES-1:0] addr_M_bus,
  input  logic [REG_WIDTH*NUM_CORES-1:0]  wr_data_M_bus,
  output logic [REG_WIDTH-1:0]            rd_data_M,
  output logic [NUM_CORES-1:0]            ready_M_bus
);
  localparam int         MEM_DEPTH    = 2**ADDR_WIDTH;
  localparam int         GRANT_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [1:0] ENABLE_READ  = 2'b01;
  localparam logic [1:0] ENABLE_WRITE = 2'b10;

  typedef enum logic {ARB, RESP} state_t;
  state_t state, state_nxt;

  logic [GRANT_W-1:0]    last_grant, grant_id, winner;
  logic [NUM_CORES-1:0]  req_vld, ready_nxt;
  logic                  found, grant_en, mem_we, rd_en;
  logic [1:0]            sel_en;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [REG_WIDTH-1:0]  sel_wdata;
  logic [REG_WIDTH-1:0]  mem [MEM_DEPTH];

  function automatic logic [GRANT_W-1:0] rr_index(input logic [GRANT_W-1:0] base,
                                                  input int offset);
    int idx;
    idx = (int'(base) + offset) % NUM_CORES;
    return GRANT_W'(idx);
  endfunction

  // A core still shows its served request during its ready cycle; mask it so it is not served twice.
  always_comb begin
    req_vld = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      req_vld[i] = ((enable_M_bus[2*i +: 2] == ENABLE_READ) ||
                    (enable_M_bus[2*i +: 2] == ENABLE_WRITE)) && !ready_M_bus[i];
    end
  end

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      if (!found && req_vld[rr_index(last_grant, k)]) begin
        found  = 1'b1;
        winner = rr_index(last_grant, k);
      end
    end
  end

  assign sel_en    = enable_M_bus[2*winner +: 2];
  assign sel_addr  = addr_M_bus[ADDR_WIDTH*winner +: ADDR_WIDTH];
  assign sel_wdata = wr_data_M_bus[REG_WIDTH*winner +: REG_WIDTH];

  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    mem_we    = 1'b0;
    rd_en     = 1'b0;
    ready_nxt = '0;
    case (state)
      ARB: begin
        if (found) begin
          state_nxt = RESP;
          grant_en  = 1'b1;
          mem_we    = (sel_en == ENABLE_WRITE);
          rd_en     = (sel_en == ENABLE_READ);
        end
      end
      RESP: begin
        state_nxt           = ARB;
        ready_nxt[grant_id] = 1'b1;
      end
      default: state_nxt = ARB;
    endcase
  end

  // ARB edge: grant and RAM access; RESP edge: ready pulse registered out
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB;
      last_grant  <= GRANT_W'(NUM_CORES - 1);
      grant_id    <= '0;
      ready_M_bus <= '0;
      rd_data_M   <= '0;
    end else begin
      state       <= state_nxt;
      ready_M_bus <= ready_nxt;
      if (grant_en) begin
        grant_id   <= winner;
        last_grant <= winner;
      end
      if (rd_en) rd_data_M <= mem[sel_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[sel_addr] <= sel_wdata;
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a table of single accesses plus hand-written sequences for
// contention, fairness, illegal enable and reset during an access; pulses checked against a queue.
module tb_data_mem_arbiter;
  localparam int         NC     = 4;
  localparam logic [1:0] EN_RD  = 2'b01;
  localparam logic [1:0] EN_WR  = 2'b10;
  localparam logic [1:0] EN_BAD = 2'b11;

  typedef struct {
    int         core;
    logic [1:0] en;
    logic [9:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  typedef struct {
    int         core;
    int         exp_cyc;
    logic [7:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [2*NC-1:0] enable;
  logic [10*NC-1:0] addr_bus;
  logic [8*NC-1:0] wdata_bus;
  logic [7:0]      rd_data_M;
  logic [NC-1:0]   ready_M_bus;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   rerq_left [NC];
  exp_t sb [$];

  data_mem_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .enable_M_bus  (enable),
    .addr_M_bus    (addr_bus),
    .wr_data_M_bus (wdata_bus),
    .rd_data_M     (rd_data_M),
    .ready_M_bus   (ready_M_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic set_req(input int c, input logic [1:0] en, input logic [9:0] a,
                         input logic [7:0] d);
    enable[2*c +: 2]     = en;
    addr_bus[10*c +: 10] = a;
    wdata_bus[8*c +: 8]  = d;
  endtask

  task automatic clr_req(input int c);
    set_req(c, 2'b00, 10'h000, 8'h00);
  endtask

  task automatic expect_pulse(input int c, input int dly, input logic [7:0] d);
    exp_t e;
    e.core    = c;
    e.exp_cyc = cyc + dly;
    e.data    = d;
    sb.push_back(e);
  endtask

  // One clock: check any pulse mid-cycle, then after the edge let served cores drop or re-request.
  task automatic step();
    logic [NC-1:0] seen;
    exp_t          rec;
    @(negedge clk);
    seen = ready_M_bus;
    if (seen != '0) begin
      if (sb.size() == 0) begin
        chk("spurious_ready", 32'(seen), 32'd0);
      end else begin
        rec = sb.pop_front();
        chk("ready_core", 32'(seen), 32'(1) << rec.core);
        chk("ready_cycle", 32'(cyc), 32'(rec.exp_cyc));
        chk("rd_data", 32'(rd_data_M), 32'(rec.data));
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NC; i++) begin
      if (seen[i]) begin
        if (rerq_left[i] > 0) rerq_left[i]--;
        else clr_req(i);
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    if (sb.size() != 0) begin
      sb.delete();
      enable = '0;
    end
  endtask

  task automatic check_quiet(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("quiet_ready", 32'(ready_M_bus), 32'd0);
    end
  endtask

  initial begin
    vec_t vecs [11];
    vecs[0]  = '{0, EN_WR, 10'h012, 8'hA5, 8'h00};
    vecs[1]  = '{0, EN_RD, 10'h012, 8'h00, 8'hA5};
    vecs[2]  = '{2, EN_WR, 10'h005, 8'h7E, 8'hA5};
    vecs[3]  = '{0, EN_RD, 10'h005, 8'h00, 8'h7E};
    vecs[4]  = '{3, EN_WR, 10'h040, 8'h10, 8'h7E};
    vecs[5]  = '{1, EN_WR, 10'h141, 8'h21, 8'h7E};
    vecs[6]  = '{0, EN_WR, 10'h242, 8'h32, 8'h7E};
    vecs[7]  = '{2, EN_WR, 10'h343, 8'h43, 8'h7E};
    vecs[8]  = '{3, EN_WR, 10'h100, 8'h00, 8'h7E};
    vecs[9]  = '{1, EN_RD, 10'h012, 8'h00, 8'hA5};
    vecs[10] = '{2, EN_RD, 10'h040, 8'h00, 8'h10};

    for (int i = 0; i < NC; i++) rerq_left[i] = 0;
    enable    = '0;
    addr_bus  = '0;
    wdata_bus = '0;
    reset     = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    chk("reset_ready", 32'(ready_M_bus), 32'd0);
    chk("reset_rd_data", 32'(rd_data_M), 32'd0);

    // Uncontended accesses: pulse two cycles after the request
    for (int i = 0; i < 11; i++) begin
      set_req(vecs[i].core, vecs[i].en, vecs[i].addr, vecs[i].wdata);
      expect_pulse(vecs[i].core, 2, vecs[i].exp_rd);
      drain(8);
    end

    // Reset restarts priority at core 0 even though core 2 was served last
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    chk("reset2_ready", 32'(ready_M_bus), 32'd0);
    chk("reset2_rd_data", 32'(rd_data_M), 32'd0);
    set_req(0, EN_RD, 10'h040, 8'h00);
    set_req(1, EN_RD, 10'h141, 8'h00);
    set_req(2, EN_RD, 10'h242, 8'h00);
    set_req(3, EN_RD, 10'h343, 8'h00);
    expect_pulse(0, 2, 8'h10);
    expect_pulse(1, 4, 8'h21);
    expect_pulse(2, 6, 8'h32);
    expect_pulse(3, 8, 8'h43);
    drain(14);

    // Cores 1 and 3 keep requesting: strict alternation
    rerq_left[1] = 2;
    rerq_left[3] = 2;
    set_req(1, EN_RD, 10'h141, 8'h00);
    set_req(3, EN_RD, 10'h343, 8'h00);
    for (int r = 0; r < 3; r++) begin
      expect_pulse(1, 2 + 4*r, 8'h21);
      expect_pulse(3, 4 + 4*r, 8'h43);
    end
    drain(20);
    check_quiet(3);

    // Enable 2'b11 is never granted and leaves memory and rd_data alone
    set_req(1, EN_BAD, 10'h012, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bad_en_ready", 32'(ready_M_bus), 32'd0);
    end
    chk("bad_en_rd_hold", 32'(rd_data_M), 32'h43);
    clr_req(1);
    set_req(0, EN_RD, 10'h012, 8'h00);
    expect_pulse(0, 2, 8'hA5);
    drain(8);

    // Reset on the grant edge: no write, no pulse
    set_req(3, EN_WR, 10'h100, 8'h55);
    reset = 1'b1;
    step();
    reset = 1'b0;
    clr_req(3);
    check_quiet(4);
    chk("rst_grant_rd_data", 32'(rd_data_M), 32'd0);
    set_req(0, EN_RD, 10'h100, 8'h00);
    expect_pulse(0, 2, 8'h00);
    drain(8);

    // Reset in RESP: pulse suppressed, committed write survives
    set_req(3, EN_WR, 10'h100, 8'h55);
    step();
    reset = 1'b1;
    clr_req(3);
    step();
    reset = 1'b0;
    check_quiet(4);
    set_req(0, EN_RD, 10'h100, 8'h00);
    expect_pulse(0, 2, 8'h55);
    drain(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
